// File: rtl/bram_stream_reader.sv
// Drains a programmed window from the 9-bit port of a block RAM into a valid/ready byte stream.
// A 2-entry buffer absorbs the 1-cycle read latency, so backpressure never drops a byte.
module bram_stream_reader #(
    parameter int ADDR_W     = 11,
    parameter int LEN_W      = 12,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_do,
    input  logic              ram_dop,
    output logic [7:0]        dout,
    output logic              dout_perr,
    output logic              dout_last,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [7:0]        perr_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [7:0]        r_data  [2];
    logic              r_perr  [2];
    logic              r_lastf [2];
    logic              r_wr;
    logic              r_rd;
    logic [1:0]        r_occ;
    logic [7:0]        r_perr_cnt;

    logic              w_pop;
    logic [2:0]        w_level;
    logic              w_issue;
    logic              w_is_final;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_podd;
    logic              w_push_perr;

    assign w_pop       = (r_occ != 2'd0) && dout_ready;
    assign w_level     = {1'b0, r_occ} + {2'b0, r_inflight};
    // The pop in this same cycle frees a slot, which is what allows 1 byte/cycle.
    assign w_issue     = (r_state == S_RUN) && (w_level < (3'd2 + {2'b0, w_pop}));
    assign w_is_final  = (r_issued == (r_len - LEN_W'(1)));
    assign w_next_addr = r_base + r_issued[ADDR_W-1:0];
    assign w_podd      = (PARITY_ODD != 0);
    assign w_push_perr = (^ram_do) ^ ram_dop ^ w_podd;

    assign ram_en     = w_issue;
    assign ram_addr   = w_issue ? w_next_addr : r_last_addr;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign dout_valid = (r_occ != 2'd0);
    assign dout       = r_data[r_rd];
    assign dout_perr  = r_perr[r_rd];
    assign dout_last  = r_lastf[r_rd];
    assign perr_count = r_perr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_base          <= '0;
            r_len           <= '0;
            r_issued        <= '0;
            r_last_addr     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_wr            <= 1'b0;
            r_rd            <= 1'b0;
            r_occ           <= 2'd0;
            r_perr_cnt      <= 8'd0;
            for (int i = 0; i < 2; i++) begin
                r_data[i]  <= 8'd0;
                r_perr[i]  <= 1'b0;
                r_lastf[i] <= 1'b0;
            end
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_is_final;
            if (w_issue) begin
                r_last_addr <= w_next_addr;
                r_issued    <= r_issued + LEN_W'(1);
            end

            if (r_inflight) begin
                r_data[r_wr]  <= ram_do;
                r_perr[r_wr]  <= w_push_perr;
                r_lastf[r_wr] <= r_inflight_last;
                r_wr          <= ~r_wr;
                if (w_push_perr && (r_perr_cnt != 8'hFF))
                    r_perr_cnt <= r_perr_cnt + 8'd1;
            end
            if (w_pop)
                r_rd <= ~r_rd;
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_perr_cnt <= 8'd0;
                        if (length == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_base   <= base_addr;
                            r_len    <= length;
                            r_issued <= '0;
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue && w_is_final)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_pop && dout_last)
                        r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: RAM model holds addr[7:0] with even parity;
// each transfer is scored against hand-derived byte/flag/timing expectations.
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] base_addr;
    logic [11:0] length;
    logic        busy, done, ram_en;
    logic [10:0] ram_addr;
    logic [7:0]  ram_do;
    logic        ram_dop;
    logic [7:0]  dout;
    logic        dout_perr, dout_last, dout_valid;
    logic        dout_ready;
    logic [7:0]  perr_count;

    int n_err = 0;
    int n_chk = 0;

    bram_stream_reader #(.ADDR_W(11), .LEN_W(12), .PARITY_ODD(0)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .ram_en(ram_en), .ram_addr(ram_addr),
        .ram_do(ram_do), .ram_dop(ram_dop), .dout(dout), .dout_perr(dout_perr),
        .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .perr_count(perr_count)
    );

    always #5 clk = ~clk;

    logic [8:0] mem [0:2047];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_do  <= mem[ram_addr][7:0];
            ram_dop <= mem[ram_addr][8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // results of the most recent run_xfer
    int cnt, mis, stab, enviol, first, donecyc, pc1, perrn, acnt, vcnt, busy_done;
    int f0 = -1;
    int f1 = -1;

    task automatic run_xfer(input logic [10:0] b, input logic [11:0] len, input int mode,
                            input bit inject);
        int tocc, prev_en, pop;
        bit pv, pr, pp, pl;
        logic [7:0]  pd;
        logic [10:0] ea;
        cnt = 0; mis = 0; stab = 0; enviol = 0; first = -1; donecyc = -1;
        pc1 = -1; perrn = 0; acnt = 0; vcnt = 0; busy_done = 0;
        @(negedge clk);
        start = 1'b1; base_addr = b; length = len; dout_ready = 1'b1;
        #1;
        prev_en = ram_en; tocc = 0; pv = 0; pr = 0; pd = 8'd0; pp = 0; pl = 0;
        for (int c = 1; c < 3000; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (inject && c == 2) begin
                start = 1'b1; base_addr = 11'h300; length = 12'd3;
            end
            if (mode == 0) dout_ready = 1'b1;
            else if (c <= 4) dout_ready = (c == 1 || c == 4);
            else dout_ready = 1'($urandom_range(0, 1));
            #1;
            if (c == 1) pc1 = perr_count;
            pop = (dout_valid && dout_ready) ? 1 : 0;
            if (dout_valid) vcnt++;
            if (pv && !pr && !(dout_valid && dout == pd && dout_perr == pp && dout_last == pl))
                stab++;
            if (ram_en && (tocc + prev_en == 2) && pop == 0) enviol++;
            if (ram_en) begin
                ea = b + 11'(acnt);
                if (ram_addr !== ea) mis++;
                acnt++;
            end
            if (pop != 0) begin
                if (first < 0) first = c;
                ea = b + 11'(cnt);
                if (dout !== ea[7:0]) mis++;
                if (dout_perr !== ((cnt == f0) || (cnt == f1))) mis++;
                if (dout_last !== (cnt == int'(len) - 1)) mis++;
                if (dout_perr) perrn++;
                cnt++;
            end
            tocc = tocc + prev_en - pop;
            prev_en = ram_en;
            pv = dout_valid; pr = dout_ready; pd = dout; pp = dout_perr; pl = dout_last;
            if (done) begin
                donecyc = c;
                busy_done = busy;
                break;
            end
        end
    endtask

    initial begin
        logic [10:0] a;
        for (int i = 0; i < 2048; i++) begin
            a = 11'(i);
            mem[i] = {^a[7:0], a[7:0]};
        end
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_perr_count", perr_count, 0);
        @(negedge clk);
        reset = 1'b0;

        // continuous, 0x10..0x13 on cycles 3..6, done on 7
        run_xfer(11'h010, 12'd4, 0, 0);
        chk("cont_count", cnt, 4);
        chk("cont_mis", mis, 0);
        chk("cont_first", first, 3);
        chk("cont_done_cyc", donecyc, 7);
        chk("cont_busy_at_done", busy_done, 1);
        chk("cont_perr_count", perr_count, 0);
        chk("cont_addrs", acnt, 4);

        // address wrap 0x7FE,0x7FF,0x000,0x001
        run_xfer(11'h7FE, 12'd4, 0, 0);
        chk("wrap_count", cnt, 4);
        chk("wrap_mis", mis, 0);
        chk("wrap_done_cyc", donecyc, 7);

        // backpressure
        for (int k = 0; k < 3; k++) begin
            run_xfer(11'h050 + 11'(k * 16), 12'd8, 1, 0);
            chk("bp_count", cnt, 8);
            chk("bp_mis", mis, 0);
            chk("bp_stable", stab, 0);
            chk("bp_issue_rule", enviol, 0);
            chk("bp_done_seen", (donecyc > 0), 1);
        end

        // parity flips on entries 2 and 5 of window 0x100
        mem[11'h102][8] = ~mem[11'h102][8];
        mem[11'h105][8] = ~mem[11'h105][8];
        f0 = 2; f1 = 5;
        run_xfer(11'h100, 12'd8, 0, 0);
        chk("par_mis", mis, 0);
        chk("par_seen", perrn, 2);
        chk("par_count", perr_count, 2);
        f0 = -1; f1 = -1;
        run_xfer(11'h010, 12'd2, 0, 0);
        chk("par_cleared_on_start", pc1, 0);
        chk("par_after_count", perr_count, 0);

        // length zero
        run_xfer(11'h200, 12'd0, 0, 0);
        chk("zero_done_cyc", donecyc, 1);
        chk("zero_valid", vcnt, 0);
        chk("zero_reads", acnt, 0);

        // start during RUN ignored
        run_xfer(11'h080, 12'd8, 0, 1);
        chk("inj_count", cnt, 8);
        chk("inj_mis", mis, 0);
        chk("inj_done_cyc", donecyc, 11);

        // reset mid-transfer; entry 2 of 0x100 still has bad parity
        @(negedge clk);
        start = 1'b1; base_addr = 11'h100; length = 12'd16; dout_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("mid_perr_before_reset", perr_count, 1);
        chk("mid_busy_before_reset", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_valid", dout_valid, 0);
        chk("mid_ram_en", ram_en, 0);
        chk("mid_perr_count", perr_count, 0);
        mem[11'h102][8] = ~mem[11'h102][8];
        mem[11'h105][8] = ~mem[11'h105][8];
        run_xfer(11'h020, 12'd3, 0, 0);
        chk("post_rst_count", cnt, 3);
        chk("post_rst_mis", mis, 0);
        chk("post_rst_done_cyc", donecyc, 6);

        // full RAM, every entry once
        run_xfer(11'h400, 12'd2048, 0, 0);
        chk("max_count", cnt, 2048);
        chk("max_reads", acnt, 2048);
        chk("max_mis", mis, 0);
        chk("max_done_cyc", donecyc, 2051);
        chk("max_perr_count", perr_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side engine for the 9-bit (8 data + 1 parity) port of a dual-port block RAM.
- The narrow port fills the RAM; this block drains a programmed window of bytes from the wide port.
- Output is a valid/ready byte stream with parity checking.
- Absorbs the RAM's 1-cycle synchronous read latency with a 2-entry output buffer, so backpressure never loses data.

Parameters:
- ADDR_W, 11, wide-port address width (2048 entries).
- LEN_W, 12, length field width (max length 2^ADDR_W).
- PARITY_ODD, 0, 0 = even parity expected (ram_dop == XOR of ram_do); 1 = odd parity expected (ram_dop == ~XOR of ram_do).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a transfer when idle.
- base_addr  in  ADDR_W  first RAM address; sampled on accepted start.
- length  in  LEN_W  number of bytes; sampled on accepted start.
- busy  out  1  high from accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse after the last byte is accepted downstream.
- ram_en  out  1  RAM port enable (read strobe).
- ram_addr  out  ADDR_W  RAM port address.
- ram_do  in  8  RAM data out; valid the cycle after ram_en.
- ram_dop  in  1  RAM parity out; valid the cycle after ram_en.
- dout  out  8  stream byte.
- dout_perr  out  1  parity mismatch for this byte.
- dout_last  out  1  marks the final byte of the transfer.
- dout_valid  out  1  stream valid.
- dout_ready  in  1  stream ready; a transfer occurs when valid and ready are both high.
- perr_count  out  8  saturating count of parity errors; cleared on accepted start.

Behaviour:
- Reset: state = IDLE; all outputs 0.
  - ram_addr = 0; buffer emptied; in-flight read discarded.
  - Applies equally mid-transfer.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with length != 0: latch base and length; clear perr_count and the issue counter; go to RUN.
  - start with length == 0: go straight to DONE; no RAM reads, no stream output.
  - start while not in IDLE is ignored.
- RUN, read issue:
  - Issue when occ + inflight − pop < 2.
    - occ = buffer entries (0..2).
    - inflight = 1 if ram_en was high the previous cycle.
    - pop = dout_valid & dout_ready this cycle.
  - On issue: ram_en = 1; ram_addr = (base + issued) mod 2^ADDR_W (wraps 2047 → 0); issued += 1.
  - ram_addr holds its last value when not issuing.
  - When issued reaches length, go to DRAIN.
- Sustained throughput: 1 byte/cycle while dout_ready stays high.
- Data capture:
  - The cycle after an issue, {ram_do, ram_dop} is pushed into the buffer.
  - dout_perr is computed at push time per PARITY_ODD.
  - dout_last is set on the entry whose index is length − 1.
  - perr_count increments on push when perr = 1 and saturates at 255.
- Output buffer: FIFO order; dout_valid = (occ != 0); dout, dout_perr and dout_last are taken from the head entry.
- Output stability: while dout_valid is high and dout_ready is low, the stream outputs hold constant.
- Simultaneous push and pop: legal, and occ is unchanged. Overflow cannot occur because of the issue rule.
- DRAIN:
  - Waits until inflight = 0 and occ = 0.
  - The last pop is the pop of the entry with dout_last = 1. After it, go to DONE.
- DONE: done = 1 for exactly one cycle; busy = 1 in this cycle; next state IDLE.
  - A start arriving in DONE is ignored.
  - A start in the following cycle (IDLE) is accepted.
- Latency: start at cycle 0 → first ram_en at cycle 1 → first dout_valid at cycle 3.
- Max length: length = 2^ADDR_W (2048) reads every entry exactly once.

Test Plan:
- Continuous transfer: RAM holds addr[7:0] with correct even parity; start base=0x010, length=4, ready=1.
  - Bytes 0x10, 0x11, 0x12, 0x13 appear on consecutive cycles from cycle 3; last is set on 0x13.
  - done pulses 1 cycle after 0x13 is accepted; perr_count = 0.
- Address wrap: base=0x7FE, length=4 → ram_addr sequence 0x7FE, 0x7FF, 0x000, 0x001; output in that order.
- Backpressure: length=8, ready toggles 1,0,0,1,… randomly.
  - Every byte is delivered exactly once, in order.
  - dout stays stable while valid=1 and ready=0.
  - ram_en is never high while occ + inflight = 2 and no pop occurs.
- Parity: entries 2 and 5 have their parity bit flipped; length=8, PARITY_ODD=0.
  - dout_perr = 1 only on bytes 2 and 5; perr_count = 2.
  - A following start clears perr_count to 0.
- Edge starts:
  - length=0 → done the cycle after start; dout_valid never asserts.
  - start pulsed during RUN is ignored; the transfer completes unchanged.
- Reset mid-transfer: reset asserted at cycle 5 of a length=16 transfer.
  - Next cycle: busy = 0, dout_valid = 0, ram_en = 0, perr_count = 0.
  - A new start then runs cleanly from its own base.
